// File: rtl/flag_sequencer.sv
// Slideshow controller for the flag index mux: debounced next/prev buttons and an
// auto-advance timer step the selector, only ever on a frame boundary.
module flag_sequencer #(
   parameter int FRAMES_PER_FLAG = 300,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int BLANK_FRAMES    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       auto_en,
   input  logic [7:0] count,
   output logic [7:0] selector,
   output logic       blank,
   output logic       changed
);

   localparam int TW = (FRAMES_PER_FLAG > 1) ? $clog2(FRAMES_PER_FLAG) : 1;
   localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

   localparam logic [TW-1:0] TIMER_LAST = TW'(FRAMES_PER_FLAG - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_FRAMES - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
   localparam bit            USE_BLANK  = (BLANK_FRAMES > 0);

   typedef enum logic {
      ST_SHOW  = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      sel_nxt;
   logic            blank_nxt;
   logic            changed_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic [BW-1:0]   bcnt, bcnt_nxt;
   logic            pend_next, pend_prev;
   logic            pend_next_nxt, pend_prev_nxt;

   // Bit 0 is the next button, bit 1 the prev button throughout.
   logic [1:0]          btn_raw, sync_q1, sync_q2;
   logic [1:0]          db_stable;
   logic [1:0][DW-1:0]  db_cnt;
   logic [1:0]          db_accept, rise;

   assign btn_raw = {btn_prev, btn_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   always_comb begin
      db_accept = '0;
      rise      = '0;
      for (int i = 0; i < 2; i++) begin
         db_accept[i] = frame_tick && (sync_q2[i] != db_stable[i]) && (db_cnt[i] == DB_LAST);
         rise[i]      = db_accept[i] && sync_q2[i];
      end
   end

   // A sample equal to the stable level restarts the run of differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_stable <= '0;
         db_cnt    <= '0;
      end else if (frame_tick) begin
         for (int i = 0; i < 2; i++) begin
            if (sync_q2[i] == db_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_accept[i]) begin
               db_stable[i] <= sync_q2[i];
               db_cnt[i]    <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   logic [8:0] sel_inc;
   logic [7:0] next_sel, prev_sel, step_val;
   logic       eff_next, eff_prev, do_step;

   assign sel_inc  = {1'b0, selector} + 9'd1;
   assign next_sel = (sel_inc >= {1'b0, count}) ? 8'd0 : sel_inc[7:0];
   assign prev_sel = (selector == 8'd0) ? (count - 8'd1) : (selector - 8'd1);
   // A request accepted on this tick is acted on in the same tick.
   assign eff_next = pend_next | rise[0];
   assign eff_prev = pend_prev | rise[1];

   always_comb begin
      state_nxt     = state;
      sel_nxt       = selector;
      blank_nxt     = blank;
      changed_nxt   = 1'b0;
      timer_nxt     = timer;
      bcnt_nxt      = bcnt;
      pend_next_nxt = eff_next;
      pend_prev_nxt = eff_prev;
      do_step       = 1'b0;
      step_val      = selector;

      if (frame_tick) begin
         if (count == 8'd0) begin
            sel_nxt       = 8'd0;
            pend_next_nxt = 1'b0;
            pend_prev_nxt = 1'b0;
            timer_nxt     = '0;
            state_nxt     = ST_SHOW;
            blank_nxt     = 1'b0;
            bcnt_nxt      = '0;
         end else if (selector >= count) begin
            // Count shrank under us; pending requests wait for a valid selector.
            step_val = 8'd0;
            do_step  = 1'b1;
         end else begin
            case (state)
               ST_SHOW: begin
                  if (eff_next ^ eff_prev) begin
                     step_val      = eff_next ? next_sel : prev_sel;
                     do_step       = 1'b1;
                     pend_next_nxt = 1'b0;
                     pend_prev_nxt = 1'b0;
                  end else begin
                     if (eff_next && eff_prev) begin
                        pend_next_nxt = 1'b0;
                        pend_prev_nxt = 1'b0;
                     end
                     if (!auto_en) begin
                        timer_nxt = '0;
                     end else if (timer == TIMER_LAST) begin
                        step_val = next_sel;
                        do_step  = 1'b1;
                     end else begin
                        timer_nxt = timer + TW'(1);
                     end
                  end
               end
               ST_BLANK: begin
                  timer_nxt = '0;
                  if (bcnt == BLANK_LAST) begin
                     state_nxt = ST_SHOW;
                     blank_nxt = 1'b0;
                     bcnt_nxt  = '0;
                  end else begin
                     bcnt_nxt = bcnt + BW'(1);
                  end
               end
               default: state_nxt = ST_SHOW;
            endcase
         end

         if (do_step) begin
            sel_nxt     = step_val;
            changed_nxt = 1'b1;
            timer_nxt   = '0;
            if (USE_BLANK) begin
               state_nxt = ST_BLANK;
               blank_nxt = 1'b1;
               bcnt_nxt  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_SHOW;
         selector  <= 8'd0;
         blank     <= 1'b0;
         changed   <= 1'b0;
         timer     <= '0;
         bcnt      <= '0;
         pend_next <= 1'b0;
         pend_prev <= 1'b0;
      end else begin
         state     <= state_nxt;
         selector  <= sel_nxt;
         blank     <= blank_nxt;
         changed   <= changed_nxt;
         timer     <= timer_nxt;
         bcnt      <= bcnt_nxt;
         pend_next <= pend_next_nxt;
         pend_prev <= pend_prev_nxt;
      end
   end

endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer: button steps, wraps, auto-advance, debounce,
// count shrink / zero handling and asynchronous reset during blanking.
module tb_flag_sequencer;

   logic       clk;
   logic       rst_n;
   logic       frame_tick;
   logic       btn_next;
   logic       btn_prev;
   logic       auto_en;
   logic [7:0] count;
   logic [7:0] selector;
   logic       blank;
   logic       changed;

   int   n_checks;
   int   n_errors;
   logic tick_changed;
   logic saw_changed;

   flag_sequencer #(
      .FRAMES_PER_FLAG(4),
      .DEBOUNCE_FRAMES(3),
      .BLANK_FRAMES   (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_tick(frame_tick),
      .btn_next  (btn_next),
      .btn_prev  (btn_prev),
      .auto_en   (auto_en),
      .count     (count),
      .selector  (selector),
      .blank     (blank),
      .changed   (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Idle long enough for the synchronisers to settle, then one frame_tick;
   // returns at the negedge where the tick's results are visible.
   task automatic frame();
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick   = 1'b0;
      tick_changed = changed;
      if (changed) saw_changed = 1'b1;
   endtask

   // Hold buttons for 3 frames, release for 3: one accepted press, blanking done.
   task automatic press(input logic nxt, input logic prv);
      btn_next = nxt;
      btn_prev = prv;
      repeat (3) frame();
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (3) frame();
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      tick_changed = 1'b0;
      saw_changed  = 1'b0;
      rst_n        = 1'b0;
      frame_tick   = 1'b0;
      btn_next     = 1'b0;
      btn_prev     = 1'b0;
      auto_en      = 1'b0;
      count        = 8'd25;

      repeat (3) @(negedge clk);
      check("rst_selector", selector, 0);
      check("rst_blank", blank, 0);
      check("rst_changed", changed, 0);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      check("tick_in_reset", selector, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // First manual step, strobe width and blanking length
      btn_next = 1'b1;
      repeat (2) frame();
      check("debounce_wait", selector, 0);
      frame();
      check("step_next", selector, 1);
      check("step_changed", tick_changed, 1);
      check("step_blank", blank, 1);
      @(negedge clk);
      check("changed_width", changed, 0);
      btn_next = 1'b0;
      frame();
      check("blank_frame2", blank, 1);
      frame();
      check("blank_release", blank, 0);
      frame();
      check("after_step", selector, 1);

      // Wrap rules at count=25
      press(1'b0, 1'b1);
      check("prev_to_0", selector, 0);
      press(1'b0, 1'b1);
      check("prev_wrap", selector, 24);
      press(1'b1, 1'b0);
      check("next_wrap", selector, 0);

      // Auto-advance with wrap 24 -> 0
      press(1'b0, 1'b1);
      check("prev_wrap_again", selector, 24);
      auto_en = 1'b1;
      repeat (3) frame();
      check("auto_hold", selector, 24);
      frame();
      check("auto_wrap", selector, 0);
      check("auto_changed", tick_changed, 1);
      repeat (6) frame();
      check("auto_period", selector, 1);
      auto_en = 1'b0;
      repeat (2) frame();
      check("auto_off_blank", blank, 0);

      // Short glitch is rejected
      saw_changed = 1'b0;
      btn_next    = 1'b1;
      repeat (2) frame();
      btn_next = 1'b0;
      repeat (3) frame();
      check("glitch_sel", selector, 1);
      check("glitch_changed", saw_changed, 0);

      // Both requests together cancel and leave nothing pending
      press(1'b1, 1'b1);
      check("both_sel", selector, 1);
      check("both_changed", saw_changed, 0);
      press(1'b1, 1'b0);
      check("flags_cleared", selector, 2);

      // prev wrap with a different count, then count shrinks below selector
      count = 8'd21;
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      check("prev_to_0_c21", selector, 0);
      press(1'b0, 1'b1);
      check("prev_wrap_c21", selector, 20);
      count = 8'd10;
      frame();
      check("shrink_sel", selector, 0);
      check("shrink_changed", tick_changed, 1);
      repeat (2) frame();
      press(1'b1, 1'b0);
      check("next_c10", selector, 1);

      // count==0 forces selector to 0 silently and ignores buttons
      count       = 8'd0;
      saw_changed = 1'b0;
      frame();
      check("zero_sel", selector, 0);
      press(1'b1, 1'b0);
      check("zero_hold", selector, 0);
      check("zero_no_changed", saw_changed, 0);

      // Reset during blanking, then timer restarts from 0
      count    = 8'd25;
      btn_next = 1'b1;
      repeat (3) frame();
      check("pre_rst_sel", selector, 1);
      check("pre_rst_blank", blank, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_sel", selector, 0);
      check("async_blank", blank, 0);
      check("async_changed", changed, 0);
      btn_next = 1'b0;
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      auto_en = 1'b1;
      repeat (3) frame();
      check("post_rst_hold", selector, 0);
      check("post_rst_blank", blank, 0);
      frame();
      check("post_rst_auto", selector, 1);
      auto_en = 1'b0;
      repeat (2) frame();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
